// File: rtl/multi_split_stream_gated.sv
// multi_split_stream_gated: 1-to-N AXI-stream broadcast with packet-boundary enable mask and per-output FIFOs.
// Define SPLIT_DROP_COUNT_EN to build the per-output skipped-packet counters.
module multi_split_stream_gated #(
    parameter int WIDTH      = 32,
    parameter int USER_WIDTH = 128,
    parameter int OUTPUTS    = 4,
    parameter int FIFO_SIZE  = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [OUTPUTS-1:0]             enable_mask,
    output logic [OUTPUTS-1:0]             active_mask,
    input  logic [WIDTH-1:0]               i_tdata,
    input  logic [USER_WIDTH-1:0]          i_tuser,
    input  logic                           i_tlast,
    input  logic                           i_tvalid,
    output logic                           i_tready,
    output logic [WIDTH*OUTPUTS-1:0]       o_tdata,
    output logic [USER_WIDTH*OUTPUTS-1:0]  o_tuser,
    output logic [OUTPUTS-1:0]             o_tlast,
    output logic [OUTPUTS-1:0]             o_tvalid,
    input  logic [OUTPUTS-1:0]             o_tready,
    output logic [16*OUTPUTS-1:0]          drop_count
);
    localparam int DEPTH = 1 << FIFO_SIZE;
    localparam int BW    = WIDTH + USER_WIDTH + 1;
    typedef enum logic {SOP, IN_PKT} state_t;
    state_t             r_state, w_next;
    logic [OUTPUTS-1:0] r_pkt_mask, w_eff_mask, w_full;
    logic               w_rst, w_accept, w_sop_accept;
    assign w_rst        = reset | clear;
    assign w_eff_mask   = (r_state == SOP) ? enable_mask : r_pkt_mask;
    assign active_mask  = w_eff_mask;
    // Only outputs taking part in the current packet may backpressure the input.
    assign i_tready     = ~w_rst & (&(~w_eff_mask | ~w_full));
    assign w_accept     = i_tvalid & i_tready;
    assign w_sop_accept = w_accept & (r_state == SOP);
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state    <= SOP;
            r_pkt_mask <= '0;
        end else begin
            r_state <= w_next;
            if (w_sop_accept && !i_tlast) r_pkt_mask <= enable_mask;
        end
    end
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? (i_tlast ? SOP : IN_PKT) : r_state;
    end
    for (genvar n = 0; n < OUTPUTS; n++) begin : g_out
        logic [BW-1:0]        r_mem [DEPTH];
        logic [FIFO_SIZE-1:0] r_wptr, r_rptr;
        logic [FIFO_SIZE:0]   r_count;
        logic                 w_push, w_pop;
        logic [BW-1:0]        w_head;
        assign w_full[n]   = r_count == (FIFO_SIZE+1)'(DEPTH);
        assign w_push      = w_accept & w_eff_mask[n];
        assign o_tvalid[n] = ~w_rst & (r_count != '0);
        assign w_pop       = o_tvalid[n] & o_tready[n];
        assign w_head      = r_mem[r_rptr];
        assign o_tlast[n]  = o_tvalid[n] & w_head[BW-1];
        assign o_tuser[USER_WIDTH*n +: USER_WIDTH] = w_head[WIDTH +: USER_WIDTH];
        assign o_tdata[WIDTH*n +: WIDTH]           = w_head[WIDTH-1:0];
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= {i_tlast, i_tuser, i_tdata};
        end
        always_ff @(posedge clk) begin
            if (w_rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + (FIFO_SIZE+1)'(w_push) - (FIFO_SIZE+1)'(w_pop);
            end
        end
`ifdef SPLIT_DROP_COUNT_EN
        logic [15:0] r_drop;
        // Counts packets this output skipped; survives clear, saturates.
        always_ff @(posedge clk) begin
            if (reset)
                r_drop <= '0;
            else if (w_sop_accept && !enable_mask[n] && r_drop != 16'hFFFF)
                r_drop <= r_drop + 1'b1;
        end
        assign drop_count[16*n +: 16] = r_drop;
`else
        assign drop_count[16*n +: 16] = '0;
`endif
    end
endmodule

// File: tb/tb_multi_split_stream_gated.sv
// tb_multi_split_stream_gated: queue-based reference model with directed scenarios and random traffic.
module tb_multi_split_stream_gated;
    localparam int W  = 32;
    localparam int UW = 16;
    localparam int NO = 4;
    localparam int FS = 2;
    localparam int DEPTH = 1 << FS;
    localparam int BW = W + UW + 1;
    logic              clk = 1'b0;
    logic              reset = 1'b1, clear = 1'b0;
    logic [NO-1:0]     enable_mask = 4'hF, active_mask;
    logic [W-1:0]      i_tdata = '0;
    logic [UW-1:0]     i_tuser = '0;
    logic              i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
    logic [W*NO-1:0]   o_tdata;
    logic [UW*NO-1:0]  o_tuser;
    logic [NO-1:0]     o_tlast, o_tvalid;
    logic [NO-1:0]     o_tready = 4'hF;
    logic [16*NO-1:0]  drop_count;
    multi_split_stream_gated #(.WIDTH(W), .USER_WIDTH(UW), .OUTPUTS(NO), .FIFO_SIZE(FS)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable_mask(enable_mask), .active_mask(active_mask),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .drop_count(drop_count)
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    logic [BW-1:0] q [NO][$];
    bit            m_in_pkt = 0;
    logic [NO-1:0] m_pkt_mask = '0;
    int            m_drop [NO];
    bit            last_acc;
    int            last_cycles;
    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endtask
    // Compare on the falling edge, then advance the model across the next rising edge.
    task automatic step();
        logic [NO-1:0] eff, v;
        bit rdy;
        @(negedge clk);
        eff = m_in_pkt ? m_pkt_mask : enable_mask;
        rdy = !(reset || clear);
        for (int n = 0; n < NO; n++) if (eff[n] && q[n].size() >= DEPTH) rdy = 0;
        chk("i_tready", 0, 64'(i_tready), 64'(rdy));
        chk("active_mask", 0, 64'(active_mask), 64'(eff));
        for (int n = 0; n < NO; n++) begin
            v[n] = !(reset || clear) && q[n].size() > 0;
            chk("o_tvalid", n, 64'(o_tvalid[n]), 64'(v[n]));
            if (v[n]) chk("beat", n, 64'({o_tlast[n], o_tuser[UW*n +: UW], o_tdata[W*n +: W]}), 64'(q[n][0]));
            chk("drop_count", n, 64'(drop_count[16*n +: 16]), 64'(m_drop[n]));
        end
        last_acc = i_tvalid && rdy;
        if (reset || clear) begin
            for (int n = 0; n < NO; n++) q[n].delete();
            m_in_pkt = 0;
            m_pkt_mask = '0;
            if (reset) for (int n = 0; n < NO; n++) m_drop[n] = 0;
        end else begin
            for (int n = 0; n < NO; n++) if (v[n] && o_tready[n]) void'(q[n].pop_front());
            if (last_acc) begin
`ifdef SPLIT_DROP_COUNT_EN
                if (!m_in_pkt)
                    for (int n = 0; n < NO; n++) if (!enable_mask[n] && m_drop[n] < 65535) m_drop[n]++;
`endif
                for (int n = 0; n < NO; n++) if (eff[n]) q[n].push_back({i_tlast, i_tuser, i_tdata});
                if (!m_in_pkt && !i_tlast) begin
                    m_in_pkt = 1;
                    m_pkt_mask = enable_mask;
                end else if (m_in_pkt && i_tlast) m_in_pkt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] d, input logic [UW-1:0] u, input logic l);
        last_cycles = 0;
        i_tvalid = 1'b1; i_tdata = d; i_tuser = u; i_tlast = l;
        do begin step(); last_cycles++; end while (!last_acc && last_cycles < 50);
        if (!last_acc) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: beat %0h not accepted in %0d cycles", d, last_cycles);
        end
        i_tvalid = 1'b0;
    endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask
    initial begin
        int acc;
        for (int n = 0; n < NO; n++) m_drop[n] = 0;
        @(posedge clk); #1;
        idle(2);
        chk("reset_tvalid", 0, 64'(o_tvalid), 64'h0);
        chk("reset_tlast", 0, 64'(o_tlast), 64'h0);
        chk("reset_tready", 0, 64'(i_tready), 64'h0);
        reset = 1'b0;
        idle(1);
        // Broadcast
        send(32'hA0, 16'h55, 1'b0);
        chk("bc_valid", 0, 64'(o_tvalid), 64'hF);
        chk("bc_data", 2, 64'(o_tdata[W*2 +: W]), 64'hA0);
        chk("bc_user", 3, 64'(o_tuser[UW*3 +: UW]), 64'h55);
        send(32'hA1, 16'h55, 1'b0);
        send(32'hA2, 16'h55, 1'b1);
        chk("bc_last", 0, 64'(o_tlast), 64'hF);
        chk("bc_data_last", 0, 64'(o_tdata[W-1:0]), 64'hA2);
        idle(3);
        // Mid-packet mask change
        send(32'hB0, 16'h1, 1'b0);
        send(32'hB1, 16'h1, 1'b0);
        enable_mask = 4'h5;
        send(32'hB2, 16'h1, 1'b0);
        chk("mid_active", 0, 64'(active_mask), 64'hF);
        send(32'hB3, 16'h1, 1'b1);
        idle(3);
        send(32'hC0, 16'h2, 1'b0);
        chk("mid_valid", 0, 64'(o_tvalid), 64'h5);
        send(32'hC1, 16'h2, 1'b1);
        idle(3);
`ifdef SPLIT_DROP_COUNT_EN
        chk("mid_drop", 0, 64'(drop_count), 64'h0001_0000_0001_0000);
`endif
        // Backpressure isolation
        enable_mask = 4'hF;
        o_tready = 4'b1011;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            i_tvalid = 1'b1; i_tdata = 32'hD0 + 32'(acc); i_tuser = 16'h3; i_tlast = (acc == 3);
            step();
            if (last_acc) acc++;
        end
        i_tvalid = 1'b0;
        chk("bp_accepted", 0, 64'(acc), 64'd4);
        chk("bp_stall", 0, 64'(i_tready), 64'h0);
        enable_mask = 4'hB;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(32'hE0 + 32'(i), 16'h4, i == 3);
            acc += last_cycles;
        end
        chk("bp_nostall", 0, 64'(acc), 64'd4);
        o_tready = 4'hF;
        idle(6);
        // All disabled, from a fresh reset
        reset = 1'b1; idle(1); reset = 1'b0;
        enable_mask = 4'h0;
        for (int i = 0; i < 5; i++) begin
            send(32'h10 + 32'(i), 16'h5, i == 4);
            chk("dis_cycles", i, 64'(last_cycles), 64'd1);
            chk("dis_valid", i, 64'(o_tvalid), 64'h0);
        end
`ifdef SPLIT_DROP_COUNT_EN
        chk("dis_drop", 0, 64'(drop_count), 64'h0001_0001_0001_0001);
`endif
        // Clear mid-packet
        enable_mask = 4'hF;
        send(32'hF0, 16'h6, 1'b0);
        send(32'hF1, 16'h6, 1'b0);
        enable_mask = 4'h3;
        clear = 1'b1; idle(1); clear = 1'b0;
        chk("clr_valid", 0, 64'(o_tvalid), 64'h0);
        chk("clr_active", 0, 64'(active_mask), 64'h3);
`ifdef SPLIT_DROP_COUNT_EN
        chk("clr_drop", 0, 64'(drop_count), 64'h0001_0001_0001_0001);
`endif
        for (int i = 0; i < 4; i++) send(32'h70 + 32'(i), 16'h7, i == 3);
        idle(4);
        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            i_tvalid = $urandom_range(0, 3) != 0;
            i_tdata  = $urandom;
            i_tuser  = UW'($urandom);
            i_tlast  = $urandom_range(0, 3) == 0;
            o_tready = NO'($urandom);
            if ($urandom_range(0, 15) == 0) enable_mask = NO'($urandom);
            clear = $urandom_range(0, 199) == 0;
            reset = $urandom_range(0, 999) == 0;
            step();
        end
        reset = 1'b0; clear = 1'b0; i_tvalid = 1'b0; o_tready = 4'hF;
        idle(6);
`ifdef SPLIT_DROP_COUNT_EN
        // Saturation
        reset = 1'b1; idle(1); reset = 1'b0;
        enable_mask = 4'hE;
        i_tvalid = 1'b1; i_tlast = 1'b1;
        acc = 0;
        for (int c = 0; c < 65700 && acc < 65540; c++) begin
            i_tdata = 32'(c);
            step();
            if (last_acc) acc++;
        end
        i_tvalid = 1'b0;
        chk("sat_beats", 0, 64'(acc), 64'd65540);
        idle(2);
        chk("sat_drop", 0, 64'(drop_count), 64'h0000_0000_0000_FFFF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
